// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if -- signal bundle between the program-counter unit and its
// surrounding pipeline (hazard unit, branch resolution, trap logic, fetch).
//
// Parameter:
//   XLEN            PC width in bits
//
// Signals (pipeline -> pc_unit):
//   pcWrite         0 stalls sequential advance
//   branchTaken     redirect to branchTarget
//   branchTarget    branch/jump destination
//   trapReq         enter trap handler
//   mretReq         return from trap to epcOut
//   haltReq         request halt
//   resume          leave halt
//
// Signals (pc_unit -> pipeline):
//   pcOut           current fetch address (registered)
//   pcPlus          pcOut + INSTR_BYTES (combinational)
//   pcValid         pcOut is a valid fetch address this cycle
//   halted          unit is halted
//   epcOut          captured trap return address
//   misalignedFault one-cycle pulse on a rejected misaligned redirect
//
// Modports:
//   master          pipeline side (drives requests, observes the PC)
//   slave           pc_unit side
// ---------------------------------------------------------------------------
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            pcWrite;
    logic            branchTaken;
    logic [XLEN-1:0] branchTarget;
    logic            trapReq;
    logic            mretReq;
    logic            haltReq;
    logic            resume;

    logic [XLEN-1:0] pcOut;
    logic [XLEN-1:0] pcPlus;
    logic            pcValid;
    logic            halted;
    logic [XLEN-1:0] epcOut;
    logic            misalignedFault;

    modport master (
        output pcWrite,
        output branchTaken,
        output branchTarget,
        output trapReq,
        output mretReq,
        output haltReq,
        output resume,
        input  pcOut,
        input  pcPlus,
        input  pcValid,
        input  halted,
        input  epcOut,
        input  misalignedFault
    );

    modport slave (
        input  pcWrite,
        input  branchTaken,
        input  branchTarget,
        input  trapReq,
        input  mretReq,
        input  haltReq,
        input  resume,
        output pcOut,
        output pcPlus,
        output pcValid,
        output halted,
        output epcOut,
        output misalignedFault
    );
endinterface

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter with sequential advance, branch/jump redirect,
// trap entry/return and a halt state.
//
// Parameters:
//   XLEN          PC width in bits (>= 8)
//   RESET_VECTOR  PC loaded by reset
//   TRAP_VECTOR   PC loaded on trap entry (and on a rejected misaligned
//                 redirect when alignment checking is enabled)
//   INSTR_BYTES   sequential PC increment
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset, dominates everything
//   bus           pc_unit_if.slave bundle (requests in, PC/status out)
//
// Build option:
//   PC_ALIGN_CHECK_EN  when defined, a branch or mret target with
//                      bits[1:0] != 0 is not loaded; the unit jumps to
//                      TRAP_VECTOR, epcOut captures the offending target
//                      and misalignedFault pulses for one cycle.
//                      When undefined, redirect targets have bits[1:0]
//                      cleared and misalignedFault is tied low.
//
// FSM states:
//   state | meaning
//   BOOT  | one cycle after reset, pcOut = RESET_VECTOR, requests ignored
//   RUN   | fetching; pcValid = 1; trap/mret/branch/halt/advance handled
//   HALT  | pcOut frozen; only trapReq and resume are honoured
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              INSTR_BYTES  = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] redir_target;

    // Wraps modulo 2^XLEN by truncation.
    assign pc_plus = pc_q + XLEN'(INSTR_BYTES);

    // mret outranks branch, so its target wins when both are requested.
    assign redir_target = bus.mretReq ? epc_q : bus.branchTarget;

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic redir_misaligned;

    assign redir_misaligned = (redir_target[1:0] != 2'b00);
`endif

    // -----------------------------------------------------------------------
    // Next-state / next-PC logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
`ifdef PC_ALIGN_CHECK_EN
        fault_d = 1'b0;
`endif

        case (state_q)
            BOOT: begin
                state_d = RUN;
                pc_d    = RESET_VECTOR;
            end

            RUN: begin
                if (bus.trapReq) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = pc_q;
                end else if (bus.mretReq || bus.branchTaken) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (redir_misaligned) begin
                        // Misaligned target is turned into a trap; the
                        // handler sees the bad target in epcOut.
                        pc_d    = TRAP_VECTOR;
                        epc_d   = redir_target;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redir_target;
                    end
`else
                    pc_d = redir_target & ~XLEN'(3);
`endif
                end else if (bus.haltReq) begin
                    // PC holds; halt is only entered when no redirect is
                    // pending in the same cycle.
                    state_d = HALT;
                end else if (bus.pcWrite) begin
                    pc_d = pc_plus;
                end
            end

            HALT: begin
                if (bus.trapReq) begin
                    state_d = RUN;
                    pc_d    = TRAP_VECTOR;
                    epc_d   = pc_q;
                end else if (bus.resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign bus.misalignedFault = fault_q;
`else
    assign bus.misalignedFault = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.pcOut   = pc_q;
    assign bus.pcPlus  = pc_plus;
    assign bus.epcOut  = epc_q;
    assign bus.pcValid = (state_q == RUN);
    assign bus.halted  = (state_q == HALT);

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- scoreboard bench for pc_unit (XLEN=32, default vectors).
// The driver applies one set of inputs per cycle, steps a reference model
// and queues the expected outputs; the monitor pops and compares after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0;
    localparam logic [31:0] TV   = 32'h100;
    localparam int          IB   = 4;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] plus;
        logic        valid;
        logic        halted;
        logic [31:0] epc;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    pc_unit_if #(.XLEN(XLEN)) bus ();

    pc_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .INSTR_BYTES  (IB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    int          m_mode;
    logic        m_fault;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Apply a redirect to target t following the architectural alignment rule.
    function automatic void model_redirect(logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        if (t % 4 != 0) begin
            m_epc   = t;
            m_pc    = TV;
            m_fault = 1'b1;
        end else begin
            m_pc = t;
        end
`else
        m_pc = t - (t % 4);
`endif
    endfunction

    task automatic step(input bit r, input bit pw, input bit br, input logic [31:0] tgt,
                        input bit tr, input bit mr, input bit hr, input bit rs);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.pcWrite      = pw;
        bus.branchTaken  = br;
        bus.branchTarget = tgt;
        bus.trapReq      = tr;
        bus.mretReq      = mr;
        bus.haltReq      = hr;
        bus.resume       = rs;

        m_fault = 1'b0;
        if (r) begin
            m_pc   = RV;
            m_epc  = 32'h0;
            m_mode = M_BOOT;
        end else if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (tr) begin
                m_epc = m_pc;
                m_pc  = TV;
            end else if (mr) begin
                model_redirect(m_epc);
            end else if (br) begin
                model_redirect(tgt);
            end else if (hr) begin
                m_mode = M_HALT;
            end else if (pw) begin
                m_pc = m_pc + IB;
            end
        end else begin
            if (tr) begin
                m_epc  = m_pc;
                m_pc   = TV;
                m_mode = M_RUN;
            end else if (rs) begin
                m_mode = M_RUN;
            end
        end

        e.pc     = m_pc;
        e.plus   = m_pc + IB;
        e.valid  = (m_mode == M_RUN);
        e.halted = (m_mode == M_HALT);
        e.epc    = m_epc;
        e.fault  = m_fault;
        q.push_back(e);
    endtask

    // Monitor: compares every cycle for which an expectation was queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pcOut",           bus.pcOut,                   e.pc);
                chk("pcPlus",          bus.pcPlus,                  e.plus);
                chk("pcValid",         32'(bus.pcValid),            32'(e.valid));
                chk("halted",          32'(bus.halted),             32'(e.halted));
                chk("epcOut",          bus.epcOut,                  e.epc);
                chk("misalignedFault", 32'(bus.misalignedFault),    32'(e.fault));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tgt;
        rst              = 1'b1;
        bus.pcWrite      = 1'b0;
        bus.branchTaken  = 1'b0;
        bus.branchTarget = '0;
        bus.trapReq      = 1'b0;
        bus.mretReq      = 1'b0;
        bus.haltReq      = 1'b0;
        bus.resume       = 1'b0;
        m_pc   = RV;
        m_epc  = 32'h0;
        m_mode = M_BOOT;
        m_fault = 1'b0;

        // reset 2 cycles, boot cycle, then sequential 0,4,8
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        // requests during boot are ignored
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h80, 1, 1, 1, 0);
        // to 0x10, branch 0x40 with pcWrite=0
        step(0, 0, 1, 32'h10, 0, 0, 0, 0);
        step(0, 0, 1, 32'h40, 0, 0, 0, 0);
        // back to 0x10, trap with pcWrite=0 -> 0x100, epc 0x10
        step(0, 1, 1, 32'h10, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        // branch 0x20, halt, hold 5 cycles with pcWrite=1, resume, advance
        step(0, 1, 1, 32'h20, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 32'h80, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // halt together with a branch: branch wins, no halt
        step(0, 1, 1, 32'h60, 0, 0, 1, 0);
        // wrap at top of address space
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // trap at 0x30 then mret
        step(0, 0, 1, 32'h30, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        // misaligned branch target
        step(0, 1, 1, 32'h42, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // trap out of halt beats resume
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0, 1);
        // reset while halted with trapReq
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 1) == 0) tgt = tgt & 32'hFFFF_FFFC;
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 tgt,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
